row_layer_mixer: RTL and testbench

Parametrised successor to the PPU's fixed three-layer pixel mixer. Given a row-start strobe, it waits until every enabled layer engine (background, foreground, sprite, or any number of extra planes) reports its row buffer ready. It then streams pixel addresses across the row, reads one pixel per layer per address and resolves per-pixel priority with transparency. The winning palette word, or a backdrop word, is written into the back row RAM. It sits inside ppu_logic between the layer engines and row_ram_swap.

---
 rtl/row_layer_mixer.sv | 250 +++++++++++++++++++++++++
 tb/tb_row_layer_mixer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_layer_mixer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : row_layer_mixer
// Description : Per-row pixel mixer for the PPU. On a row-start strobe it
//               waits for every enabled layer engine to report its row buffer
//               ready. It then sweeps pixel addresses 0..ROW_WIDTH-1, reads
//               one pixel per layer per address and resolves priority with
//               transparency. The winning palette word (or the backdrop word)
//               is written into the back row RAM.
// Revision    : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
// Ports:
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   start_i             single-cycle row-start strobe; aborts a row in flight
//   layer_en_i          layer enable mask, sampled on start
//   backdrop_i          word written where no enabled layer is opaque
//   layer_done_i        level, per layer: row buffer ready
//   pixel_addr_o        pixel address broadcast to all layers
//   layer_pixel_data_i  layer i pixel word at [i*DATA_W +: DATA_W]
//   layer_pixel_prio_i  layer i priority   at [i*PRIO_W +: PRIO_W]
//   rowram_wrdata_o     resolved pixel word
//   rowram_wraddr_o     row RAM write address
//   rowram_wren_o       row RAM write enable
//   busy_o              high whenever the mixer is not idle
//   row_done_o          one-cycle pulse after the last write of a row
// ============================================================================
module row_layer_mixer #(
  parameter  int NUM_LAYERS = 3,
  parameter  int ROW_WIDTH  = 320,
  parameter  int DATA_W     = 9,
  parameter  int CIDX_W     = 4,
  parameter  int PRIO_W     = 2,
  parameter  int READ_LAT   = 1,
  localparam int ADDR_W     = $clog2(ROW_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [NUM_LAYERS-1:0]        layer_en_i,
  input  logic [DATA_W-1:0]            backdrop_i,
  input  logic [NUM_LAYERS-1:0]        layer_done_i,
  output logic [ADDR_W-1:0]            pixel_addr_o,
  input  logic [NUM_LAYERS*DATA_W-1:0] layer_pixel_data_i,
  input  logic [NUM_LAYERS*PRIO_W-1:0] layer_pixel_prio_i,
  output logic [DATA_W-1:0]            rowram_wrdata_o,
  output logic [ADDR_W-1:0]            rowram_wraddr_o,
  output logic                         rowram_wren_o,
  output logic                         busy_o,
  output logic                         row_done_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SCAN  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_WIDTH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]            state_q,    state_d;
  logic [NUM_LAYERS-1:0] en_q,       en_d;
  logic [DATA_W-1:0]     bd_q,       bd_d;
  logic [ADDR_W-1:0]     addr_q,     addr_d;
  logic                  row_done_q, row_done_d;

  // Read pipeline: tracks which issued addresses are still waiting for their
  // layer data, and which address each one belongs to.
  logic [READ_LAT-1:0]   vld_q;
  logic [ADDR_W-1:0]     padr_q [READ_LAT];

  // Registered write port.
  logic                  wren_q,   wren_d;
  logic [ADDR_W-1:0]     wraddr_q;
  logic [DATA_W-1:0]     wrdata_q, wrdata_d;

  logic                  issue;
  logic                  flush;
  logic                  layers_ready;
  logic                  pipe_empty;

  // Disabled layers count as ready so they can never stall the row.
  assign layers_ready = &(layer_done_i | ~en_q);
  assign pipe_empty   = ~|vld_q;

  // Any start (idle or mid-row) discards whatever is in flight.
  assign flush = start_i;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    bd_d       = bd_q;
    addr_d     = addr_q;
    row_done_d = 1'b0;
    issue      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Start handling is shared with the abort path below.
      end

      S_WAIT: begin
        if (layers_ready) begin
          state_d = S_SCAN;
          addr_d  = '0;
        end
      end

      S_SCAN: begin
        issue = 1'b1;
        if (addr_q == LAST_ADDR) begin
          // Address holds at the last pixel; it never wraps.
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      S_DRAIN: begin
        // The last write registers in the cycle the pipeline empties, so
        // row_done lands exactly one cycle after that write is visible.
        if (pipe_empty) begin
          state_d    = S_IDLE;
          row_done_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Start in IDLE begins a row; start anywhere else aborts the current one.
    // Either way the row restarts from WAIT with fresh enables and backdrop,
    // and an aborted row never reports completion.
    if (start_i) begin
      en_d       = layer_en_i;
      bd_d       = backdrop_i;
      state_d    = S_WAIT;
      addr_d     = '0;
      row_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      en_q       <= '0;
      bd_q       <= '0;
      addr_q     <= '0;
      row_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      bd_q       <= bd_d;
      addr_q     <= addr_d;
      row_done_q <= row_done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read-latency pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < READ_LAT; k++) begin
        padr_q[k] <= '0;
      end
    end else begin
      vld_q[0]  <= issue & ~flush;
      padr_q[0] <= addr_q;
      for (int k = 1; k < READ_LAT; k++) begin
        vld_q[k]  <= vld_q[k-1] & ~flush;
        padr_q[k] <= padr_q[k-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Priority resolution
  // Walk layers from index 0 upward and replace the winner only on strictly
  // higher priority, so equal priorities keep the lower layer index.
  // --------------------------------------------------------------------------
  logic              win_found;
  logic [PRIO_W-1:0] win_prio;
  logic [DATA_W-1:0] cur_data;
  logic [PRIO_W-1:0] cur_prio;

  always_comb begin
    win_found = 1'b0;
    win_prio  = '0;
    wrdata_d  = bd_q;
    cur_data  = '0;
    cur_prio  = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      cur_data = layer_pixel_data_i[i*DATA_W +: DATA_W];
      cur_prio = layer_pixel_prio_i[i*PRIO_W +: PRIO_W];
      if (en_q[i] && (cur_data[CIDX_W-1:0] != '0)) begin
        if (!win_found || (cur_prio > win_prio)) begin
          win_found = 1'b1;
          win_prio  = cur_prio;
          wrdata_d  = cur_data;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write port
  // A start in the same cycle as a pending write kills it, so nothing from an
  // aborted row reaches the RAM after the abort.
  // --------------------------------------------------------------------------
  assign wren_d = vld_q[READ_LAT-1] & ~start_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
    end else begin
      wren_q <= wren_d;
      if (wren_d) begin
        wraddr_q <= padr_q[READ_LAT-1];
        wrdata_q <= wrdata_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pixel_addr_o    = addr_q;
  assign rowram_wren_o   = wren_q;
  assign rowram_wraddr_o = wraddr_q;
  assign rowram_wrdata_o = wrdata_q;
  assign busy_o          = (state_q != S_IDLE);
  assign row_done_o      = row_done_q;

endmodule
`default_nettype wire

// File: tb/tb_row_layer_mixer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_row_layer_mixer
// Description : Self-checking bench for row_layer_mixer. A small layer-RAM
//               model answers pixel_addr with one cycle of latency; expected
//               writes are queued when each row is started and popped as the
//               mixer writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_row_layer_mixer;

  localparam int NL = 3;
  localparam int RW = 320;
  localparam int DW = 9;
  localparam int PW = 2;
  localparam int AW = 9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [NL-1:0]   layer_en = '0;
  logic [NL-1:0]   layer_done = '0;
  logic [DW-1:0]   backdrop = '0;
  logic [NL*DW-1:0] lpd = '0;
  logic [NL*PW-1:0] lpp = '0;

  logic [AW-1:0]   pixel_addr;
  logic [DW-1:0]   wrdata;
  logic [AW-1:0]   wraddr;
  logic            wren;
  logic            busy;
  logic            row_done;

  int n_pass  = 0;
  int n_total = 0;

  // Layer contents: mode 0 = constant word/prio per layer, 1 = address-varying.
  int              mode = 0;
  logic [DW-1:0]   cw [NL];
  logic [PW-1:0]   cp [NL];

  typedef struct {
    int addr;
    int data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  row_layer_mixer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_i            (start),
    .layer_en_i         (layer_en),
    .backdrop_i         (backdrop),
    .layer_done_i       (layer_done),
    .pixel_addr_o       (pixel_addr),
    .layer_pixel_data_i (lpd),
    .layer_pixel_prio_i (lpp),
    .rowram_wrdata_o    (wrdata),
    .rowram_wraddr_o    (wraddr),
    .rowram_wren_o      (wren),
    .busy_o             (busy),
    .row_done_o         (row_done)
  );

  function automatic logic [DW-1:0] word_of(int i, int a);
    if (mode == 0) return cw[i];
    return DW'((a * 37 + i * 101) % 512);
  endfunction

  function automatic logic [PW-1:0] prio_of(int i, int a);
    if (mode == 0) return cp[i];
    return PW'(((a >> i) + i) & 3);
  endfunction

  // Reference: find the highest opaque priority, then the lowest layer with it.
  function automatic int ref_pix(logic [NL-1:0] en, logic [DW-1:0] bd, int a);
    int            best;
    logic [DW-1:0] w;
    best = -1;
    for (int i = 0; i < NL; i++) begin
      w = word_of(i, a);
      if (en[i] && w[3:0] != 4'd0 && int'(prio_of(i, a)) > best) best = int'(prio_of(i, a));
    end
    if (best < 0) return int'(bd);
    for (int i = 0; i < NL; i++) begin
      w = word_of(i, a);
      if (en[i] && w[3:0] != 4'd0 && int'(prio_of(i, a)) == best) return int'(w);
    end
    return int'(bd);
  endfunction

  // Layer RAM model: one cycle from address to data.
  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      lpd[i*DW +: DW] <= word_of(i, int'(pixel_addr));
      lpp[i*PW +: PW] <= prio_of(i, int'(pixel_addr));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n && wren) begin
      if (sb.size() == 0) begin
        chk("stray_write_addr", 32'(wraddr), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wraddr", 32'(wraddr), 32'(e.addr));
        chk("wrdata", 32'(wrdata), 32'(e.data));
      end
    end
  end

  task automatic set_layers(input logic [DW-1:0] w0, input logic [PW-1:0] p0,
                            input logic [DW-1:0] w1, input logic [PW-1:0] p1,
                            input logic [DW-1:0] w2, input logic [PW-1:0] p2);
    mode  = 0;
    cw[0] = w0; cp[0] = p0;
    cw[1] = w1; cp[1] = p1;
    cw[2] = w2; cp[2] = p2;
  endtask

  task automatic push_row(input logic [NL-1:0] en, input logic [DW-1:0] bd);
    exp_t e;
    for (int a = 0; a < RW; a++) begin
      e.addr = a;
      e.data = ref_pix(en, bd, a);
      sb.push_back(e);
    end
  endtask

  // Pulse start for one cycle, then scramble enable/backdrop so that a mixer
  // failing to latch them on start would misbehave.
  task automatic start_row(input logic [NL-1:0] en, input logic [DW-1:0] bd);
    push_row(en, bd);
    @(posedge clk); #1;
    layer_en = en;
    backdrop = bd;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    layer_en = ~en;
    backdrop = ~bd;
  endtask

  task automatic finish_row(input string tag, input int exp_first);
    int   cyc, first, last, nwr, done_at;
    logic gap_ok, busy_at_done;
    cyc = 0; first = -1; last = -1; nwr = 0; done_at = -1;
    gap_ok = 1'b1; busy_at_done = 1'b1;
    while (cyc < 3000 && done_at < 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({tag, "_busy_t1"}, 32'(busy), 32'd1);
      if (wren) begin
        nwr++;
        if (first < 0) first = cyc;
        else if (last != cyc - 1) gap_ok = 1'b0;
        last = cyc;
      end
      if (row_done) begin
        done_at      = cyc;
        busy_at_done = busy;
      end
    end
    chk({tag, "_row_done_seen"}, 32'(done_at >= 0), 32'd1);
    chk({tag, "_nwrites"}, 32'(nwr), 32'(RW));
    chk({tag, "_no_gaps"}, 32'(gap_ok), 32'd1);
    chk({tag, "_done_after_last"}, 32'(done_at - last), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    if (exp_first >= 0) chk({tag, "_first_latency"}, 32'(first), 32'(exp_first));
  endtask

  task automatic wait_addr(input string tag, input int val);
    int found;
    found = 0;
    for (int c = 0; c < 2000 && found == 0; c++) begin
      @(negedge clk);
      if (int'(pixel_addr) == val) found = 1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic quiet(input string tag, input int n, input logic rd_allowed_busy);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (wren || row_done || (busy && !rd_allowed_busy)) ok = 1'b0;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pixel_addr", 32'(pixel_addr), 32'd0);
    chk("rst_wrdata", 32'(wrdata), 32'd0);
    chk("rst_wraddr", 32'(wraddr), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_row_done", 32'(row_done), 32'd0);
    rst_n = 1'b1;

    // Basic priority: layer0 transparent, layer2 highest prio wins
    layer_done = 3'b111;
    set_layers(9'h010, 2'd0, 9'h012, 2'd1, 9'h034, 2'd2);
    start_row(3'b111, 9'h000);
    finish_row("basic", 4);

    // Equal priority: lower index wins; then layer0 drops below
    set_layers(9'h021, 2'd3, 9'h030, 2'd0, 9'h043, 2'd3);
    start_row(3'b111, 9'h000);
    finish_row("tie", 4);
    set_layers(9'h021, 2'd2, 9'h030, 2'd0, 9'h043, 2'd3);
    start_row(3'b111, 9'h000);
    finish_row("tie_lower", 4);

    // All enabled layers transparent -> backdrop
    set_layers(9'h010, 2'd3, 9'h020, 2'd2, 9'h0F0, 2'd1);
    start_row(3'b111, 9'h1F0);
    finish_row("backdrop", 4);

    // No layers enabled: WAIT passes with layer_done all low
    layer_done = 3'b000;
    set_layers(9'h011, 2'd3, 9'h022, 2'd3, 9'h033, 2'd3);
    start_row(3'b000, 9'h1F0);
    finish_row("en_none", 4);

    // Disabled layer neither stalls nor wins
    layer_done = 3'b101;
    set_layers(9'h011, 2'd1, 9'h0FF, 2'd3, 9'h0E0, 2'd2);
    start_row(3'b101, 9'h1F0);
    finish_row("iso", 4);

    // Address-varying contents exercise data/address alignment
    layer_done = 3'b111;
    mode = 1;
    start_row(3'b111, 9'h155);
    finish_row("vary", 4);

    // Stall: layer2 not ready for 50 cycles
    layer_done = 3'b011;
    set_layers(9'h010, 2'd0, 9'h012, 2'd1, 9'h034, 2'd2);
    start_row(3'b111, 9'h000);
    quiet("stall_busy_no_wren", 50, 1'b1);
    chk("stall_still_busy", 32'(busy), 32'd1);
    layer_done = 3'b111;
    finish_row("stall", -1);

    // Abort at pixel_addr 100, restart with different contents
    mode = 1;
    start_row(3'b111, 9'h000);
    wait_addr("abort_reach_100", 100);
    #1;
    sb.delete();
    set_layers(9'h055, 2'd1, 9'h066, 2'd2, 9'h077, 2'd0);
    push_row(3'b111, 9'h000);
    layer_en = 3'b111;
    backdrop = 9'h000;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    finish_row("abort", -1);
    quiet("abort_single_row_done", 20, 1'b0);

    // Reset in the middle of a scan
    start_row(3'b111, 9'h000);
    wait_addr("rst_reach_150", 150);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_pixel_addr", 32'(pixel_addr), 32'd0);
    chk("midrst_wrdata", 32'(wrdata), 32'd0);
    chk("midrst_wraddr", 32'(wraddr), 32'd0);
    chk("midrst_wren", 32'(wren), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_row_done", 32'(row_done), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet("post_rst_quiet", 30, 1'b0);
    start_row(3'b111, 9'h000);
    finish_row("recover", 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
